// File: rtl/l1_l2_refill_unit_if.sv
// L2 request/response bus between the L1 refill unit (master) and the L2 (slave).
// The signal names match the original flat ports, so that existing port maps
// can be moved into this interface.
interface l1_l2_refill_unit_if;
  logic        l2_req_valid_o;
  logic        l2_req_ready_i;
  logic [63:0] l2_req_addr_o;
  logic        l2_req_write_o;
  logic [63:0] l2_req_wdata_o;
  logic [63:0] l2_resp_rdata_i;

  modport master (
    output l2_req_valid_o,
    output l2_req_addr_o,
    output l2_req_write_o,
    output l2_req_wdata_o,
    input  l2_req_ready_i,
    input  l2_resp_rdata_i
  );

  modport slave (
    input  l2_req_valid_o,
    input  l2_req_addr_o,
    input  l2_req_write_o,
    input  l2_req_wdata_o,
    output l2_req_ready_i,
    output l2_resp_rdata_i
  );
endinterface

// File: rtl/l1_l2_refill_unit.sv
// L1 line refill unit. It accepts one miss at a time. When the victim is
// dirty, it first writes the victim back as eight 64-bit write beats. It then
// fetches the missing line as eight 64-bit read beats. The read data is
// sampled a fixed RD_LAT cycles after each read request is accepted.
// Optional build macro REFILL_CRIT_WORD_FIRST_EN: when it is defined, reads
// start at the missed word and wrap modulo 8. Without it, reads go in word
// order 0..7.
module l1_l2_refill_unit #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [63:0]         miss_addr_i,
  input  logic                evict_valid_i,
  input  logic [63:0]         evict_addr_i,
  input  logic [511:0]        evict_data_i,
  output logic                refill_valid_o,
  input  logic                refill_ready_i,
  output logic [63:0]         refill_addr_o,
  output logic [511:0]        refill_data_o,
  l1_l2_refill_unit_if.master l2
);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  // r_wait starts at 0 in the first cycle after the accept, so the capture
  // cycle (RD_LAT cycles after the accept) is reached when r_wait == RD_LAT-1.
  localparam logic [3:0] LP_WAIT_LAST = 4'(RD_LAT - 1);

  state_t         r_state;
  state_t         w_next;

  logic [57:0]    r_miss_line;
  logic [57:0]    r_evict_line;
  logic [511:0]   r_evict_data;
  logic [2:0]     r_beat;
  logic [2:0]     r_idx;
  logic [2:0]     r_rd_cnt;
  logic [3:0]     r_wait;
  logic [511:0]   r_line;

  logic           w_miss_hs;
  logic           w_wr_hs;
  logic           w_rd_hs;
  logic           w_capture;
  logic [2:0]     w_rd_start;
  logic           w_unused;

`ifdef REFILL_CRIT_WORD_FIRST_EN
  assign w_rd_start = miss_addr_i[5:3];
  assign w_unused   = ^{miss_addr_i[2:0], evict_addr_i[5:0]};
`else
  assign w_rd_start = 3'd0;
  assign w_unused   = ^{miss_addr_i[5:0], evict_addr_i[5:0]};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, bus outputs and handshake strobes
  always_comb begin
    w_next            = r_state;
    miss_ready_o      = 1'b0;
    refill_valid_o    = 1'b0;
    refill_addr_o     = '0;
    refill_data_o     = '0;
    l2.l2_req_valid_o = 1'b0;
    l2.l2_req_addr_o  = '0;
    l2.l2_req_write_o = 1'b0;
    l2.l2_req_wdata_o = '0;
    w_miss_hs         = 1'b0;
    w_wr_hs           = 1'b0;
    w_rd_hs           = 1'b0;
    w_capture         = 1'b0;
    case (r_state)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          w_miss_hs = 1'b1;
          w_next    = evict_valid_i ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        l2.l2_req_valid_o = 1'b1;
        l2.l2_req_write_o = 1'b1;
        l2.l2_req_addr_o  = {r_evict_line, r_beat, 3'b000};
        l2.l2_req_wdata_o = r_evict_data[{r_beat, 6'b000} +: 64];
        if (l2.l2_req_ready_i) begin
          w_wr_hs = 1'b1;
          if (r_beat == 3'd7) begin
            w_next = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        l2.l2_req_valid_o = 1'b1;
        l2.l2_req_addr_o  = {r_miss_line, r_idx, 3'b000};
        if (l2.l2_req_ready_i) begin
          w_rd_hs = 1'b1;
          w_next  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_wait == LP_WAIT_LAST) begin
          w_capture = 1'b1;
          w_next    = (r_rd_cnt == 3'd7) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        refill_valid_o = 1'b1;
        refill_addr_o  = {r_miss_line, 6'b000000};
        refill_data_o  = r_line;
        if (refill_ready_i) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Miss latch, beat/wait counters and refill line buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_line  <= '0;
      r_evict_line <= '0;
      r_evict_data <= '0;
      r_beat       <= '0;
      r_idx        <= '0;
      r_rd_cnt     <= '0;
      r_wait       <= '0;
      r_line       <= '0;
    end else begin
      if (w_miss_hs) begin
        r_miss_line  <= miss_addr_i[63:6];
        r_evict_line <= evict_addr_i[63:6];
        r_evict_data <= evict_data_i;
        r_beat       <= '0;
        r_idx        <= w_rd_start;
        r_rd_cnt     <= '0;
        r_wait       <= '0;
      end
      // r_beat wraps back to 0 after beat 7, ready for the next victim
      if (w_wr_hs) begin
        r_beat <= r_beat + 3'd1;
      end
      if (w_rd_hs) begin
        r_wait <= '0;
      end else if (r_state == RD_WAIT && !w_capture) begin
        r_wait <= r_wait + 4'd1;
      end
      // r_idx advances modulo 8, which makes the critical-word-first order wrap
      if (w_capture) begin
        r_line[{r_idx, 6'b000} +: 64] <= l2.l2_resp_rdata_i;
        r_idx                         <= r_idx + 3'd1;
        r_rd_cnt                      <= r_rd_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_l1_l2_refill_unit.sv
// Testbench for l1_l2_refill_unit. An L2 model accepts requests, inserts
// configurable stalls and returns read data RD_LAT cycles after each accept.
// Expected beats and refill lines are queued at issue time and compared
// against the logged L2 accepts and the refill outputs.
module tb_l1_l2_refill_unit;
`ifdef REFILL_CRIT_WORD_FIRST_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 1;
`endif
  localparam int BEAT = 1 + RD_LAT;

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [63:0] wdata;
    int          cyc;
  } beat_t;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_valid;
  logic         miss_ready;
  logic [63:0]  miss_addr;
  logic         evict_valid;
  logic [63:0]  evict_addr;
  logic [511:0] evict_data;
  logic         refill_valid;
  logic         refill_ready;
  logic [63:0]  refill_addr;
  logic [511:0] refill_data;

  l1_l2_refill_unit_if l2();

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    stab_err = 0;
  int    stall_wr_idx = -1;
  int    stall_wr_n = 0;
  int    stall_rd_idx = -1;
  int    stall_rd_n = 0;
  beat_t exp_q[$];
  beat_t acc_q[$];
  pend_t pend_q[$];

  l1_l2_refill_unit #(.RD_LAT(RD_LAT)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss_valid_i   (miss_valid),
    .miss_ready_o   (miss_ready),
    .miss_addr_i    (miss_addr),
    .evict_valid_i  (evict_valid),
    .evict_addr_i   (evict_addr),
    .evict_data_i   (evict_data),
    .refill_valid_o (refill_valid),
    .refill_ready_i (refill_ready),
    .refill_addr_o  (refill_addr),
    .refill_data_o  (refill_data),
    .l2             (l2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rd_data(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F1E_2D3C_4B5A_6978;
  endfunction

  // L2 model: ready/stall generation, accept log, stability watch and read return
  initial begin : l2_model
    int          left;
    bit          stalled;
    logic [63:0] pa;
    logic [63:0] pd;
    logic        pw;
    pend_t       p;
    left = 0;
    stalled = 0;
    pa = '0;
    pd = '0;
    pw = 1'b0;
    l2.l2_req_ready_i  = 1'b0;
    l2.l2_resp_rdata_i = '0;
    forever begin
      @(negedge clk);
      l2.l2_resp_rdata_i = {$urandom, $urandom};
      if (rst_n !== 1'b1) begin
        pend_q.delete();
        left = 0;
        stalled = 0;
        l2.l2_req_ready_i = 1'b0;
        continue;
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        if (p.due == cyc) l2.l2_resp_rdata_i = rd_data(p.addr);
      end
      if (stalled && (l2.l2_req_valid_o !== 1'b1 || l2.l2_req_addr_o !== pa ||
                      l2.l2_req_write_o !== pw || l2.l2_req_wdata_o !== pd))
        stab_err++;
      if (l2.l2_req_valid_o === 1'b1 && !stalled) begin
        if (l2.l2_req_write_o && int'(l2.l2_req_addr_o[5:3]) == stall_wr_idx) begin
          left = stall_wr_n;
          stall_wr_idx = -1;
        end else if (!l2.l2_req_write_o && int'(l2.l2_req_addr_o[5:3]) == stall_rd_idx) begin
          left = stall_rd_n;
          stall_rd_idx = -1;
        end
      end
      if (left > 0) begin
        l2.l2_req_ready_i = 1'b0;
        left--;
      end else begin
        l2.l2_req_ready_i = (l2.l2_req_valid_o === 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (l2.l2_req_valid_o === 1'b1 && l2.l2_req_ready_i) begin
        acc_q.push_back(beat_t'{l2.l2_req_addr_o, l2.l2_req_write_o, l2.l2_req_wdata_o, cyc});
        if (!l2.l2_req_write_o) pend_q.push_back(pend_t'{cyc + RD_LAT, l2.l2_req_addr_o});
        stalled = 0;
      end else if (l2.l2_req_valid_o === 1'b1) begin
        stalled = 1;
        pa = l2.l2_req_addr_o;
        pw = l2.l2_req_write_o;
        pd = l2.l2_req_wdata_o;
      end else begin
        stalled = 0;
      end
    end
  end

  // Drive a miss and queue the expected L2 beats and refill line
  task automatic issue_miss(input logic [63:0] ma, input logic ev, input logic [63:0] ea,
                            input logic [511:0] ed, input bit hold,
                            output int t, output logic [511:0] line);
    int          n;
    int          base;
    logic [2:0]  idx;
    logic [63:0] a;
    miss_valid  = 1'b1;
    miss_addr   = ma;
    evict_valid = ev;
    evict_addr  = ea;
    evict_data  = ed;
    n = 0;
    while (miss_ready !== 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    tests++;
    if (miss_ready !== 1'b1) begin
      fails++;
      $display("FAIL miss_accept: miss_ready=%b required 1", miss_ready);
    end
    t = cyc;
    line = '0;
    if (ev)
      for (int i = 0; i < 8; i++)
        exp_q.push_back(beat_t'{{ea[63:6], 3'(i), 3'b000}, 1'b1, ed[64*i +: 64], t + 1 + i});
    base = t + 1 + (ev ? 8 : 0);
    for (int k = 0; k < 8; k++) begin
`ifdef REFILL_CRIT_WORD_FIRST_EN
      idx = ma[5:3] + 3'(k);
`else
      idx = 3'(k);
`endif
      a = {ma[63:6], idx, 3'b000};
      exp_q.push_back(beat_t'{a, 1'b0, 64'h0, base + k * BEAT});
      line[64*idx +: 64] = rd_data(a);
    end
    @(negedge clk); #1;
    if (!hold) miss_valid = 1'b0;
    evict_valid = 1'($urandom_range(0, 1));
    evict_addr  = {$urandom, $urandom};
    evict_data  = {16{$urandom}};
  endtask

  // Wait (bounded) for refill_valid; d = -1 when the budget expires
  task automatic wait_refill(output int d);
    int n;
    n = 0;
    while (refill_valid !== 1'b1 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    d = (refill_valid === 1'b1) ? cyc : -1;
  endtask

  task automatic take_refill();
    refill_ready = 1'b1;
    @(negedge clk); #1;
    refill_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({miss_ready, refill_valid, l2.l2_req_valid_o, l2.l2_req_write_o} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctrl: got ready/rvalid/l2valid/l2write=%b required 1000",
               {miss_ready, refill_valid, l2.l2_req_valid_o, l2.l2_req_write_o});
    end
    tests++;
    if ({refill_addr, l2.l2_req_addr_o, l2.l2_req_wdata_o} !== 192'h0) begin
      fails++;
      $display("FAIL reset_addr: got refill_addr=%h l2_addr=%h l2_wdata=%h required 0",
               refill_addr, l2.l2_req_addr_o, l2.l2_req_wdata_o);
    end
    tests++;
    if (refill_data !== 512'h0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0", refill_data);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_read_only();
    int t; int d; logic [511:0] line; beat_t e; beat_t a;
    issue_miss(64'h1000_0048, 1'b0, 64'h0, 512'h0, 1'b0, t, line);
    wait_refill(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL rd_beat: got no request, required addr=%h", e.addr);
      end else begin
        a = acc_q.pop_front();
        if (a.addr !== e.addr || a.wr !== e.wr || a.cyc != e.cyc) begin
          fails++;
          $display("FAIL rd_beat: got addr=%h wr=%b cyc=%0d required addr=%h wr=%b cyc=%0d",
                   a.addr, a.wr, a.cyc, e.addr, e.wr, e.cyc);
        end
      end
    end
    tests++;
    if (d != t + 1 + 8 * BEAT) begin
      fails++;
      $display("FAIL rd_refill_cycle: got T+%0d required T+%0d", d - t, 1 + 8 * BEAT);
    end
    tests++;
    if (refill_addr !== 64'h1000_0040 || refill_data !== line) begin
      fails++;
      $display("FAIL rd_refill_line: got addr=%h data=%h required addr=%h data=%h",
               refill_addr, refill_data, 64'h1000_0040, line);
    end
    take_refill();
    tests++;
    if (miss_ready !== 1'b1 || refill_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_idle_after: got miss_ready=%b refill_valid=%b required 1 0",
               miss_ready, refill_valid);
    end
  endtask

  task automatic test_writeback();
    int t; int d; logic [511:0] line; logic [511:0] ed; beat_t e; beat_t a;
    for (int i = 0; i < 8; i++) ed[64*i +: 64] = 64'hA0 + 64'(i);
    issue_miss(64'h3000_0000, 1'b1, 64'h2000_0000, ed, 1'b0, t, line);
    wait_refill(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL wb_beat: got no request, required addr=%h", e.addr);
      end else begin
        a = acc_q.pop_front();
        if (a.addr !== e.addr || a.wr !== e.wr || (e.wr && a.wdata !== e.wdata) || a.cyc != e.cyc) begin
          fails++;
          $display("FAIL wb_beat: got addr=%h wr=%b wdata=%h cyc=%0d required addr=%h wr=%b wdata=%h cyc=%0d",
                   a.addr, a.wr, a.wdata, a.cyc, e.addr, e.wr, e.wdata, e.cyc);
        end
      end
    end
    tests++;
    if (d != t + 9 + 8 * BEAT) begin
      fails++;
      $display("FAIL wb_refill_cycle: got T+%0d required T+%0d", d - t, 9 + 8 * BEAT);
    end
    tests++;
    if (refill_addr !== 64'h3000_0000 || refill_data !== line) begin
      fails++;
      $display("FAIL wb_refill_line: got addr=%h data=%h required addr=%h data=%h",
               refill_addr, refill_data, 64'h3000_0000, line);
    end
    take_refill();
  endtask

  task automatic test_stall();
    int t; int d; logic [511:0] line; logic [511:0] ed; beat_t e; beat_t a;
    for (int i = 0; i < 16; i++) ed[32*i +: 32] = $urandom;
    stab_err = 0;
    stall_wr_idx = 2; stall_wr_n = 3;
    stall_rd_idx = 5; stall_rd_n = 2;
    issue_miss(64'h5000_0088, 1'b1, 64'h6000_0040, ed, 1'b0, t, line);
    wait_refill(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL stall_beat: got no request, required addr=%h", e.addr);
      end else begin
        a = acc_q.pop_front();
        if (a.addr !== e.addr || a.wr !== e.wr || (e.wr && a.wdata !== e.wdata)) begin
          fails++;
          $display("FAIL stall_beat: got addr=%h wr=%b wdata=%h required addr=%h wr=%b wdata=%h",
                   a.addr, a.wr, a.wdata, e.addr, e.wr, e.wdata);
        end
      end
    end
    tests++;
    if (stab_err !== 0) begin
      fails++;
      $display("FAIL stall_stability: got %0d unstable cycles required 0", stab_err);
    end
    tests++;
    if (d != t + 9 + 8 * BEAT + 5) begin
      fails++;
      $display("FAIL stall_refill_cycle: got T+%0d required T+%0d", d - t, 14 + 8 * BEAT);
    end
    tests++;
    if (refill_addr !== 64'h5000_0080 || refill_data !== line) begin
      fails++;
      $display("FAIL stall_refill_line: got addr=%h data=%h required addr=%h data=%h",
               refill_addr, refill_data, 64'h5000_0080, line);
    end
    take_refill();
  endtask

  task automatic test_back_to_back();
    int t; int t2; int d; int dd; logic [511:0] line; logic [511:0] line2; beat_t e; beat_t a;
    issue_miss(64'h0800_0100, 1'b0, 64'h0, 512'h0, 1'b1, t, line);
    wait_refill(d);
    tests++;
    if (d != t + 1 + 8 * BEAT) begin
      fails++;
      $display("FAIL b2b_refill_cycle: got T+%0d required T+%0d", d - t, 1 + 8 * BEAT);
    end
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (refill_valid !== 1'b1 || refill_addr !== 64'h0800_0100 || refill_data !== line ||
          l2.l2_req_valid_o !== 1'b0 || miss_ready !== 1'b0 || acc_q.size() != 0) begin
        fails++;
        $display("FAIL b2b_hold: cycle %0d got rvalid=%b addr=%h l2valid=%b mready=%b accepts=%0d required 1 %h 0 0 0",
                 i, refill_valid, refill_addr, l2.l2_req_valid_o, miss_ready, acc_q.size(), 64'h0800_0100);
      end
      @(negedge clk); #1;
    end
    dd = cyc;
    take_refill();
    tests++;
    if (miss_ready !== 1'b1 || l2.l2_req_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got miss_ready=%b l2valid=%b required 1 0", miss_ready, l2.l2_req_valid_o);
    end
    issue_miss(64'h0900_0040, 1'b0, 64'h0, 512'h0, 1'b0, t2, line2);
    tests++;
    if (t2 != dd + 1) begin
      fails++;
      $display("FAIL b2b_second_accept: got D+%0d required D+1", t2 - dd);
    end
    wait_refill(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL b2b_beat: got no request, required addr=%h", e.addr);
      end else begin
        a = acc_q.pop_front();
        if (a.addr !== e.addr || a.wr !== e.wr || a.cyc != e.cyc) begin
          fails++;
          $display("FAIL b2b_beat: got addr=%h wr=%b cyc=%0d required addr=%h wr=%b cyc=%0d",
                   a.addr, a.wr, a.cyc, e.addr, e.wr, e.cyc);
        end
      end
    end
    tests++;
    if (refill_addr !== 64'h0900_0040 || refill_data !== line2) begin
      fails++;
      $display("FAIL b2b_refill_line: got addr=%h data=%h required addr=%h data=%h",
               refill_addr, refill_data, 64'h0900_0040, line2);
    end
    take_refill();
  endtask

  task automatic test_reset_midflight();
    int t; int d; int n; bit found; logic [511:0] line; beat_t e; beat_t a;
    issue_miss(64'h7000_0000, 1'b0, 64'h0, 512'h0, 1'b0, t, line);
    n = 0;
    found = 0;
    while (!found && n < 200) begin
      if (acc_q.size() > 0) begin
        a = acc_q[$];
        if (!a.wr && a.addr[5:3] == 3'd3) found = 1;
      end
      if (!found) begin
        @(negedge clk); #1;
        n++;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL rst_reach_beat3: got no read of word 3 required one");
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({miss_ready, refill_valid, l2.l2_req_valid_o, l2.l2_req_write_o} !== 4'b1000 ||
        {refill_addr, l2.l2_req_addr_o, l2.l2_req_wdata_o} !== 192'h0 || refill_data !== 512'h0) begin
      fails++;
      $display("FAIL rst_outputs: got ready/rvalid/l2valid/l2write=%b addr=%h l2addr=%h required 1000 0 0",
               {miss_ready, refill_valid, l2.l2_req_valid_o, l2.l2_req_write_o}, refill_addr, l2.l2_req_addr_o);
    end
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    issue_miss(64'h7100_0000, 1'b0, 64'h0, 512'h0, 1'b0, t, line);
    wait_refill(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (acc_q.size() == 0) begin
        fails++;
        $display("FAIL rst_beat: got no request, required addr=%h", e.addr);
      end else begin
        a = acc_q.pop_front();
        if (a.addr !== e.addr || a.wr !== e.wr || a.cyc != e.cyc) begin
          fails++;
          $display("FAIL rst_beat: got addr=%h wr=%b cyc=%0d required addr=%h wr=%b cyc=%0d",
                   a.addr, a.wr, a.cyc, e.addr, e.wr, e.cyc);
        end
      end
    end
    tests++;
    if (d != t + 1 + 8 * BEAT || refill_addr !== 64'h7100_0000 || refill_data !== line) begin
      fails++;
      $display("FAIL rst_refill: got T+%0d addr=%h data=%h required T+%0d addr=%h data=%h",
               d - t, refill_addr, refill_data, 1 + 8 * BEAT, 64'h7100_0000, line);
    end
    take_refill();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n        = 1'b0;
    miss_valid   = 1'b0;
    miss_addr    = '0;
    evict_valid  = 1'b0;
    evict_addr   = '0;
    evict_data   = '0;
    refill_ready = 1'b0;
    test_reset();
    test_read_only();
    test_writeback();
    test_stall();
    test_back_to_back();
    test_reset_midflight();
    tests++;
    if (acc_q.size() != 0) begin
      fails++;
      $display("FAIL extra_requests: got %0d unexpected L2 accepts required 0", acc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
